// File: rtl/edge_detect_multi.sv
// N-channel edge detector with per-channel mode, optional input synchroniser,
// registered ticks, sticky write-1-to-clear pending flags and a saturating event counter.
module edge_detect_multi #(
   parameter int unsigned N           = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     level,
   input  logic [2*N-1:0]   mode,
   input  logic [N-1:0]     pend_clr,
   input  logic             cnt_clr,
   output logic [N-1:0]     tick,
   output logic [N-1:0]     pending,
   output logic             irq,
   output logic [CNT_W-1:0] evt_cnt
);

   localparam int unsigned PC_W  = $clog2(N + 1);
   localparam int unsigned SUM_W = (CNT_W >= PC_W) ? CNT_W + 1 : PC_W + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [N-1:0]      s;
   logic [N-1:0]      prev;
   logic [N-1:0]      rise;
   logic [N-1:0]      fall;
   logic [N-1:0]      det;
   logic [N-1:0]      pend_next;
   logic [PC_W-1:0]   pc;
   logic [SUM_W-1:0]  base;
   logic [SUM_W-1:0]  sum;

   // Level synchroniser; zero stages passes level straight through.
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = level;
      end else begin : g_sync
         logic [N-1:0] sync_q [SYNC_STAGES];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
            end else begin
               sync_q[0] <= level;
               for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
            end
         end

         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Per-channel edge selection; mode is applied combinationally to this cycle's compare.
   always_comb begin
      rise = s & ~prev;
      fall = ~s & prev;
      det  = '0;
      for (int i = 0; i < int'(N); i++) begin
         case (mode[2*i +: 2])
            2'b01:   det[i] = rise[i];
            2'b10:   det[i] = fall[i];
            2'b11:   det[i] = rise[i] | fall[i];
            default: det[i] = 1'b0;
         endcase
      end
   end

   // Event count, counter next value and pending next value (set wins over clear).
   always_comb begin
      pc = '0;
      for (int i = 0; i < int'(N); i++) pc = pc + PC_W'(det[i]);
      base      = cnt_clr ? '0 : SUM_W'(evt_cnt);
      sum       = base + SUM_W'(pc);
      pend_next = (pending & ~pend_clr) | det;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev    <= '0;
         tick    <= '0;
         pending <= '0;
         irq     <= 1'b0;
         evt_cnt <= '0;
      end else begin
         prev    <= s;
         tick    <= det;
         pending <= pend_next;
         irq     <= |pend_next;
         evt_cnt <= (sum > CNT_MAX) ? '1 : CNT_W'(sum);
      end
   end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Randomised scoreboard bench for edge_detect_multi: two instances (8ch/2-stage/16-bit
// and 4ch/no-sync/4-bit) checked against a delay-line reference model.
module tb_edge_detect_multi;

   typedef struct packed {
      logic [7:0]  tick;
      logic [7:0]  pend;
      logic        irq;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  level;
   logic [15:0] mode;
   logic [7:0]  pend_clr;
   logic        cnt_clr;

   logic [7:0]  tick0, pending0;
   logic        irq0;
   logic [15:0] cnt0;
   logic [3:0]  tick1, pending1;
   logic        irq1;
   logic [3:0]  cnt1;

   int checks = 0;
   int errors = 0;

   exp_t q0[$];
   exp_t q1[$];

   // Model state: last three sampled levels, previous synchronised value, pending, count.
   logic [7:0] hist [2][3];
   logic [7:0] prev_s [2];
   logic [7:0] e_pend [2];
   int         e_cnt [2];

   edge_detect_multi #(.N(8), .SYNC_STAGES(2), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .level(level), .mode(mode), .pend_clr(pend_clr),
      .cnt_clr(cnt_clr), .tick(tick0), .pending(pending0), .irq(irq0), .evt_cnt(cnt0));

   edge_detect_multi #(.N(4), .SYNC_STAGES(0), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset), .level(level[3:0]), .mode(mode[7:0]), .pend_clr(pend_clr[3:0]),
      .cnt_clr(cnt_clr), .tick(tick1), .pending(pending1), .irq(irq1), .evt_cnt(cnt1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, d, $time, act, exp);
      end
   endtask

   // One clock of reference behaviour: s is the level sampled 'st' edges ago.
   function automatic exp_t model(input int d, input int n, input int st, input int cmax);
      logic [7:0] msk, cur, sv, rise, fall, det;
      int         base;
      exp_t       e;
      msk = (n == 8) ? 8'hFF : 8'h0F;
      if (reset) begin
         for (int k = 0; k < 3; k++) hist[d][k] = '0;
         prev_s[d] = '0;
         e_pend[d] = '0;
         e_cnt[d]  = 0;
         return '0;
      end
      cur  = level & msk;
      sv   = (st == 0) ? cur : hist[d][st-1];
      rise = sv & ~prev_s[d];
      fall = ~sv & prev_s[d];
      det  = '0;
      for (int i = 0; i < n; i++) begin
         case (mode[2*i +: 2])
            2'b01:   det[i] = rise[i];
            2'b10:   det[i] = fall[i];
            2'b11:   det[i] = rise[i] | fall[i];
            default: det[i] = 1'b0;
         endcase
      end
      base     = cnt_clr ? 0 : e_cnt[d];
      e_cnt[d] = base + $countones(det);
      if (e_cnt[d] > cmax) e_cnt[d] = cmax;
      e_pend[d] = ((e_pend[d] & ~pend_clr) | det) & msk;
      prev_s[d] = sv;
      hist[d][2] = hist[d][1];
      hist[d][1] = hist[d][0];
      hist[d][0] = cur;
      e.tick = det;
      e.pend = e_pend[d];
      e.irq  = (e_pend[d] != 0);
      e.cnt  = 16'(e_cnt[d]);
      return e;
   endfunction

   // Reference model runs on the same edge the DUT samples its inputs.
   always @(posedge clk) begin
      q0.push_back(model(0, 8, 2, 65535));
      q1.push_back(model(1, 4, 0, 15));
   end

   // Monitor: pops one expected record per DUT per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q0.size() == 0 || q1.size() == 0) begin
            chk("queue_empty", 0, 32'(q0.size() + q1.size()), 32'd2);
         end else begin
            e = q0.pop_front();
            if (reset) e = '0;
            chk("tick", 0, 32'(tick0), 32'(e.tick));
            chk("pending", 0, 32'(pending0), 32'(e.pend));
            chk("irq", 0, 32'(irq0), 32'(e.irq));
            chk("evt_cnt", 0, 32'(cnt0), 32'(e.cnt));
            e = q1.pop_front();
            if (reset) e = '0;
            chk("tick", 1, 32'(tick1), 32'(e.tick[3:0]));
            chk("pending", 1, 32'(pending1), 32'(e.pend[3:0]));
            chk("irq", 1, 32'(irq1), 32'(e.irq));
            chk("evt_cnt", 1, 32'(cnt1), 32'(e.cnt[3:0]));
         end
      end
   end

   task automatic cyc(input logic [7:0] l, input logic [15:0] m, input logic [7:0] pc, input logic cc);
      @(posedge clk);
      #1;
      level    = l;
      mode     = m;
      pend_clr = pc;
      cnt_clr  = cc;
   endtask

   task automatic hold(input int n, input logic [7:0] l, input logic [15:0] m);
      for (int i = 0; i < n; i++) cyc(l, m, 8'h00, 1'b0);
   endtask

   initial begin
      logic [7:0] lv;
      reset = 1'b1; level = '0; mode = '0; pend_clr = '0; cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Single rising edge, all channels in rising mode.
      hold(3, 8'h00, 16'h5555);
      hold(6, 8'h01, 16'h5555);

      // Channel 3: falling-only, then both, then off.
      hold(5, 8'h08, 16'h5595);
      hold(5, 8'h00, 16'h5595);
      hold(5, 8'h08, 16'h5595);
      hold(5, 8'h00, 16'h55D5);
      hold(5, 8'h08, 16'h55D5);
      hold(5, 8'h00, 16'h5515);
      hold(5, 8'h08, 16'h5515);

      // All channels rise together, then clear everything.
      hold(4, 8'h00, 16'h5555);
      hold(5, 8'hFF, 16'h5555);
      cyc(8'hFF, 16'h5555, 8'hFF, 1'b0);

      // Clear coinciding with a new edge on channel 2, then a plain clear.
      hold(3, 8'hFB, 16'h5555);
      for (int i = 0; i < 4; i++) cyc(8'hFF, 16'h5555, 8'h04, 1'b0);
      hold(3, 8'hFF, 16'h5555);
      cyc(8'hFF, 16'h5555, 8'h04, 1'b0);
      cyc(8'hFF, 16'h5555, 8'hFB, 1'b0);
      hold(3, 8'hFF, 16'h5555);

      // Saturation on the 4-bit counter, then clear coinciding with 3 edges.
      cyc(8'h00, 16'hFFFF, 8'h00, 1'b1);
      cyc(8'h00, 16'hFFFF, 8'h00, 1'b1);
      for (int i = 0; i < 5; i++) cyc((i % 2 == 0) ? 8'h0F : 8'h00, 16'hFFFF, 8'h00, 1'b0);
      @(posedge clk); @(negedge clk);
      chk("sat_hold", 1, 32'(cnt1), 32'd15);
      cyc(8'h08, 16'hFFFF, 8'h00, 1'b1);
      @(posedge clk); @(negedge clk);
      chk("clr_with_edges", 1, 32'(cnt1), 32'd3);

      // Reset with edges in flight; level held high through release.
      hold(4, 8'h00, 16'h5555);
      hold(1, 8'hFF, 16'h5555);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("reset_irq", 0, 32'(irq0), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      hold(6, 8'hFF, 16'h5555);

      // Randomised traffic.
      lv = 8'h00;
      for (int i = 0; i < 800; i++) begin
         lv = lv ^ 8'($urandom & $urandom);
         cyc(lv, 16'($urandom), 8'($urandom & $urandom & $urandom), ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 199) == 0) begin
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
         end
      end
      hold(3, lv, 16'h0000);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
